// File: rtl/lot_gate_multi.sv
// Multi-lane parking-lot gate controller.
// Each lane synchronises and debounces its outer (a) and inner (b) sensors and
// tracks vehicle direction; a shared saturating counter tracks occupancy.

// Single-bit two-flop synchroniser followed by a consecutive-sample debouncer.
module lot_gate_deb #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [1:0]    sync;
  logic [DW-1:0] cnt;

  // sync[1] is the metastability-safe sample; filt flips after DEBOUNCE differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE - 1)) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// One gate lane: input filtering, direction FSM, timeout and rearm logic.
module lot_gate_lane #(
  parameter int DEBOUNCE = 3,
  parameter int TIMEOUT  = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter_nxt,
  output logic exit_nxt,
  output logic enter,
  output logic exit,
  output logic abort
);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A} state_t;

  state_t        state;
  logic [TW-1:0] tmr;
  logic          rearm;
  logic          fa, fb, tmo;
  logic [1:0]    ab;

  lot_gate_deb #(.DEBOUNCE(DEBOUNCE)) u_deb_a (.clk(clk), .reset(reset), .raw(a), .filt(fa));
  lot_gate_deb #(.DEBOUNCE(DEBOUNCE)) u_deb_b (.clk(clk), .reset(reset), .raw(b), .filt(fb));

  assign ab = {fa, fb};

  // Timer would reach TIMEOUT on this edge; it outranks any completion.
  always_comb begin
    tmo       = (state != IDLE) && (tmr == TW'(TIMEOUT - 1));
    enter_nxt = !tmo && (state == IN_B)  && (ab == 2'b00);
    exit_nxt  = !tmo && (state == OUT_A) && (ab == 2'b00);
  end

  // Direction FSM with registered pulses; after an abort the lane waits for 00 to rearm.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tmr   <= '0;
      rearm <= 1'b1;
      enter <= 1'b0;
      exit  <= 1'b0;
      abort <= 1'b0;
    end else begin
      enter <= enter_nxt;
      exit  <= exit_nxt;
      abort <= tmo;
      tmr   <= (state == IDLE) ? '0 : tmr + 1'b1;
      if (tmo) begin
        state <= IDLE;
        rearm <= 1'b0;
        tmr   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (ab == 2'b00)                rearm <= 1'b1;
            else if (rearm && ab == 2'b10)  state <= IN_A;
            else if (rearm && ab == 2'b01)  state <= OUT_B;
          end
          IN_A: case (ab)
            2'b10:   state <= IN_A;
            2'b11:   state <= IN_AB;
            default: state <= IDLE;
          endcase
          IN_AB: case (ab)
            2'b11:   state <= IN_AB;
            2'b01:   state <= IN_B;
            2'b10:   state <= IN_A;
            default: state <= IDLE;
          endcase
          IN_B: case (ab)
            2'b01:   state <= IN_B;
            2'b11:   state <= IN_AB;
            default: state <= IDLE;
          endcase
          OUT_B: case (ab)
            2'b01:   state <= OUT_B;
            2'b11:   state <= OUT_AB;
            default: state <= IDLE;
          endcase
          OUT_AB: case (ab)
            2'b11:   state <= OUT_AB;
            2'b10:   state <= OUT_A;
            2'b01:   state <= OUT_B;
            default: state <= IDLE;
          endcase
          OUT_A: case (ab)
            2'b10:   state <= OUT_A;
            2'b11:   state <= OUT_AB;
            default: state <= IDLE;
          endcase
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// Top: lane array plus shared occupancy counter.
module lot_gate_multi #(
  parameter  int NUM_LANES = 2,
  parameter  int CAPACITY  = 16,
  parameter  int DEBOUNCE  = 3,
  parameter  int TIMEOUT   = 64,
  localparam int CW        = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] a,
  input  logic [NUM_LANES-1:0] b,
  output logic [NUM_LANES-1:0] enter,
  output logic [NUM_LANES-1:0] exit,
  output logic [NUM_LANES-1:0] abort,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int SW = CW + 4;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  logic [NUM_LANES-1:0] enter_nxt, exit_nxt;
  logic signed [SW-1:0] sum;
  logic [CW-1:0]        count_nxt;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lot_gate_lane #(.DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)) u_lane (
      .clk(clk), .reset(reset), .a(a[g]), .b(b[g]),
      .enter_nxt(enter_nxt[g]), .exit_nxt(exit_nxt[g]),
      .enter(enter[g]), .exit(exit[g]), .abort(abort[g])
    );
  end

  // Net all same-edge entries and exits first, then clamp once.
  always_comb begin
    sum = SW'(count);
    for (int i = 0; i < NUM_LANES; i++)
      sum = sum + SW'(enter_nxt[i]) - SW'(exit_nxt[i]);
    if (sum > CAP_S)     count_nxt = CW'(CAPACITY);
    else if (sum[SW-1])  count_nxt = '0;
    else                 count_nxt = sum[CW-1:0];
  end

  // Count, flags and clip pulses all update on the edge the lane pulses register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      full      <= (count_nxt == CW'(CAPACITY));
      empty     <= (count_nxt == '0);
      overflow  <= (sum > CAP_S);
      underflow <= sum[SW-1];
    end
  end
endmodule

// File: tb/tb_lot_gate_multi.sv
// Bench for lot_gate_multi: directed table, random scenario rounds against an
// event-level occupancy model, and hand-written latency/glitch/timeout/reset cases.
module tb_lot_gate_multi;
  localparam int NL = 2, CAP = 3, DB = 2, TO = 16;

  logic       clk = 1'b0, reset = 1'b1;
  logic [1:0] a = '0, b = '0;
  logic [1:0] enter, exit, abort, count;
  logic       full, empty, overflow, underflow;

  lot_gate_multi #(.NUM_LANES(NL), .CAPACITY(CAP), .DEBOUNCE(DB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .enter(enter), .exit(exit), .abort(abort),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  int vecs = 0, errs = 0, cyc = 0, ab_last = 0;
  int n_en[2] = '{0, 0}, n_ex[2] = '{0, 0}, n_ab[2] = '{0, 0}, n_ov = 0, n_un = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // pulse counters sampled mid-cycle
  always @(negedge clk) if (reset) begin
    for (int i = 0; i < NL; i++) begin
      n_en[i] <= n_en[i] + int'(enter[i]);
      n_ex[i] <= n_ex[i] + int'(exit[i]);
      n_ab[i] <= n_ab[i] + int'(abort[i]);
    end
    n_ov <= n_ov + int'(overflow);
    n_un <= n_un + int'(underflow);
    if (abort[0]) ab_last <= cyc;
  end

  typedef logic [0:3][1:0] seq_t;
  localparam seq_t SE  = {2'b10, 2'b11, 2'b01, 2'b00};  // entry
  localparam seq_t SX  = {2'b01, 2'b11, 2'b10, 2'b00};  // exit
  localparam seq_t SB  = {2'b10, 2'b11, 2'b10, 2'b00};  // entry backs out
  localparam seq_t SB2 = {2'b01, 2'b11, 2'b01, 2'b00};  // exit backs out
  localparam seq_t SJ  = {2'b10, 2'b01, 2'b01, 2'b00};  // illegal jump
  localparam seq_t SN  = {2'b00, 2'b00, 2'b00, 2'b00};  // nothing

  typedef struct {
    seq_t s0, s1;
    int en0, en1, ex0, ex1, cnt, ov, un;
  } vec_t;
  vec_t tbl[9];

  seq_t scn[5];
  int   scn_d[5];
  int   mc, mov, mun;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] ab0, input logic [1:0] ab1, input int n);
    a = {ab1[1], ab0[1]};
    b = {ab1[0], ab0[0]};
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] pat(input seq_t s, input int t);
    if (t < 0 || t >= 12) return 2'b00;
    return s[t / 3];
  endfunction

  // each pattern held 3 cycles after a per-lane offset, then a long 00 tail
  task automatic round(input seq_t s0, input seq_t s1, input int o0, input int o1);
    for (int t = 0; t < 28; t++) begin
      logic [1:0] p0, p1;
      p0 = pat(s0, t - o0);
      p1 = pat(s1, t - o1);
      step(p0, p1, 1);
    end
  endtask

  task automatic run_chk(input string nm, input seq_t s0, input seq_t s1, input int o0, input int o1,
                         input int e0, input int e1, input int x0, input int x1,
                         input int ec, input int eov, input int eun);
    int pe0, pe1, px0, px1, pov, pun, pab;
    pe0 = n_en[0]; pe1 = n_en[1]; px0 = n_ex[0]; px1 = n_ex[1];
    pov = n_ov; pun = n_un; pab = n_ab[0] + n_ab[1];
    round(s0, s1, o0, o1);
    chk({nm, " enter0"}, n_en[0] - pe0, e0);
    chk({nm, " enter1"}, n_en[1] - pe1, e1);
    chk({nm, " exit0"}, n_ex[0] - px0, x0);
    chk({nm, " exit1"}, n_ex[1] - px1, x1);
    chk({nm, " abort"}, n_ab[0] + n_ab[1] - pab, 0);
    chk({nm, " count"}, int'(count), ec);
    chk({nm, " full"}, int'(full), int'(ec == CAP));
    chk({nm, " empty"}, int'(empty), int'(ec == 0));
    chk({nm, " overflow"}, n_ov - pov, eov);
    chk({nm, " underflow"}, n_un - pun, eun);
  endtask

  task automatic do_reset();
    a = '0; b = '0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic void model_apply(input int d);
    int v;
    v = mc + d;
    if (v > CAP) begin mov++; v = CAP; end
    else if (v < 0) begin mun++; v = 0; end
    mc = v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int first, hi, pe, c0, pab, k0, k1, o0, o1, ov0, un0;

    tbl[0] = '{SE, SN, 1, 0, 0, 0, 1, 0, 0};
    tbl[1] = '{SN, SX, 0, 0, 0, 1, 0, 0, 0};
    tbl[2] = '{SN, SX, 0, 0, 0, 1, 0, 0, 1};  // exit from empty lot clips
    tbl[3] = '{SB, SN, 0, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{SE, SE, 1, 1, 0, 0, 2, 0, 0};
    tbl[5] = '{SE, SX, 1, 0, 0, 1, 2, 0, 0};  // same-edge entry/exit nets out
    tbl[6] = '{SE, SE, 1, 1, 0, 0, 3, 1, 0};  // 2+2 clipped to 3
    tbl[7] = '{SX, SX, 0, 0, 1, 1, 1, 0, 0};
    tbl[8] = '{SX, SX, 0, 0, 1, 1, 0, 0, 1};  // 1-2 clipped to 0
    scn = '{SE, SX, SB, SB2, SJ};
    scn_d = '{1, -1, 0, 0, 0};

    // reset state
    #1 reset = 1'b0;
    #3;
    chk("rst count", int'(count), 0);
    chk("rst empty", int'(empty), 1);
    chk("rst full", int'(full), 0);
    chk("rst pulses", int'({enter, exit, abort, overflow, underflow}), 0);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    // raw-to-pulse latency: 3+DEBOUNCE edges, one cycle wide
    step(2'b10, 2'b00, 4);
    step(2'b11, 2'b00, 4);
    step(2'b01, 2'b00, 4);
    a = '0; b = '0;
    first = -1; hi = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #3;
      if (enter[0]) begin
        hi++;
        if (first < 0) first = k;
      end
    end
    chk("lat edge", first, 3 + DB);
    chk("lat width", hi, 1);
    chk("lat count", int'(count), 1);
    chk("lat empty", int'(empty), 0);

    do_reset();
    foreach (tbl[i])
      run_chk($sformatf("tbl%0d", i), tbl[i].s0, tbl[i].s1, 0, 0, tbl[i].en0, tbl[i].en1,
              tbl[i].ex0, tbl[i].ex1, tbl[i].cnt, tbl[i].ov, tbl[i].un);

    // random scenario rounds against the occupancy model
    mc = tbl[8].cnt;
    for (int r = 0; r < 40; r++) begin
      k0 = $urandom_range(4); k1 = $urandom_range(4);
      o0 = $urandom_range(2); o1 = $urandom_range(2);
      mov = 0; mun = 0;
      if (o0 == o1) model_apply(scn_d[k0] + scn_d[k1]);
      else if (o0 < o1) begin model_apply(scn_d[k0]); model_apply(scn_d[k1]); end
      else begin model_apply(scn_d[k1]); model_apply(scn_d[k0]); end
      ov0 = mov; un0 = mun;
      run_chk($sformatf("rnd%0d", r), scn[k0], scn[k1], o0, o1,
              int'(scn_d[k0] > 0), int'(scn_d[k1] > 0), int'(scn_d[k0] < 0), int'(scn_d[k1] < 0),
              mc, ov0, un0);
    end

    // one-cycle drop to 00 while in IN_B must not complete the entry early
    do_reset();
    pe = n_en[0];
    step(2'b10, 2'b00, 3);
    step(2'b11, 2'b00, 3);
    step(2'b01, 2'b00, 2);
    step(2'b00, 2'b00, 1);
    step(2'b01, 2'b00, 5);
    chk("glitch early", n_en[0] - pe, 0);
    step(2'b00, 2'b00, 10);
    chk("glitch enter", n_en[0] - pe, 1);
    chk("glitch count", int'(count), 1);

    // timeout: abort 16 edges after leaving IDLE, then no entry until rearmed by 00
    do_reset();
    pab = n_ab[0]; pe = n_en[0];
    c0 = cyc;
    step(2'b10, 2'b00, 30);
    chk("tmo aborts", n_ab[0] - pab, 1);
    chk("tmo edge", ab_last - c0, 2 + DB + 1 + TO);
    step(2'b11, 2'b00, 4);
    step(2'b01, 2'b00, 4);
    step(2'b00, 2'b00, 8);
    chk("tmo norearm", n_en[0] - pe, 0);
    run_chk("rearm", SE, SN, 0, 0, 1, 0, 0, 0, 1, 0, 0);

    // asynchronous reset with lane 0 sitting in IN_B
    do_reset();
    round(SE, SE, 0, 0);
    chk("pre-rst count", int'(count), 2);
    step(2'b10, 2'b00, 3);
    step(2'b11, 2'b00, 3);
    step(2'b01, 2'b00, 5);
    #1 reset = 1'b0;
    #1;
    chk("arst count", int'(count), 0);
    chk("arst empty", int'(empty), 1);
    chk("arst full", int'(full), 0);
    #1 reset = 1'b1;
    pe = n_en[0];
    step(2'b00, 2'b00, 12);
    chk("arst no enter", n_en[0] - pe, 0);
    chk("arst count2", int'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
